// File: rtl/period_meas_scheduler_pkg.sv
// Shared types and constants for the period measurement scheduler.
package period_meas_pkg;

  localparam int PERIOD_W = 10;
  localparam logic [PERIOD_W-1:0] PERIOD_TIMEOUT = 10'h3FF;
  localparam int CLK_MS_COUNT_DEF = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_CLEAR
  } pm_state_e;

endpackage

// File: rtl/period_meas_scheduler_if.sv
// Handshake between the scheduler (master) and the shared period counter (slave).
interface period_meas_scheduler_if;
  import period_meas_pkg::*;

  logic                pc_si;
  logic                pc_start;
  logic                pc_clr;
  logic                pc_ready;
  logic                pc_done;
  logic [PERIOD_W-1:0] pc_period;

  modport master (
    output pc_si, pc_start, pc_clr,
    input  pc_ready, pc_done, pc_period
  );

  modport slave (
    input  pc_si, pc_start, pc_clr,
    output pc_ready, pc_done, pc_period
  );

endinterface

// File: rtl/period_meas_scheduler_rr_pick.sv
// Combinational round-robin picker: first set mask bit after last_i, wrapping,
// with last_i itself as the final candidate.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    grant_o = last_i;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % N);
      if (mask_i[idx]) grant_o = idx;
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/period_meas_scheduler.sv
// Round-robin scheduler sharing one period counter across N_CH inputs.
//
// state  | meaning
// IDLE   | pick next enabled channel, hold sel
// SETTLE | mux switched, let the counter input settle
// START  | wait for counter ready, issue start
// WAIT   | wait for done or ms timeout
// STORE  | result published this cycle
// CLEAR  | counter cleared this cycle
module period_meas_scheduler
  import period_meas_pkg::*;
#(
  parameter  int N_CH          = 4,
  parameter  int CLK_MS_COUNT  = CLK_MS_COUNT_DEF,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int TIMEOUT_MS    = 2047,
  localparam int CH_W          = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable_i,
  input  logic [N_CH-1:0]         chan_en_i,
  input  logic [N_CH-1:0]         si_i,
  period_meas_scheduler_if.master pc_if,
  output logic                    result_valid_o,
  output logic [CH_W-1:0]         result_chan_o,
  output logic [PERIOD_W-1:0]     result_period_o,
  output logic                    result_timeout_o,
  output logic                    busy_o
);

  localparam int PRE_W = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_MS + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  pm_state_e           state_q, state_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                pc_start_q, pc_start_d;
  logic                pc_clr_q, pc_clr_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_chan_q, res_chan_d;
  logic [PERIOD_W-1:0] res_period_q, res_period_d;
  logic                res_tmo_q, res_tmo_d;
  logic                busy_q;

  logic [CH_W-1:0]     pick_grant;
  logic                pick_any;
  logic                settle_done;
  logic                presc_wrap;
  logic                tmo_hit;

  rr_pick #(.N(N_CH)) u_pick (
    .mask_i  (chan_en_i),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  // The start pulse is registered, so the START cycle itself is the last
  // settled cycle before the counter sees start; SETTLE is one shorter.
  assign settle_done = (int'(settle_q) + 2 >= SETTLE_CYCLES);
  assign presc_wrap  = (presc_q == PRE_W'(CLK_MS_COUNT - 1));
  assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_MS));

  // Next-state and next-output logic; outputs are registered from the transition.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    settle_d     = settle_q;
    presc_d      = presc_q;
    tmo_d        = tmo_q;
    pc_start_d   = 1'b0;
    res_valid_d  = 1'b0;
    res_chan_d   = res_chan_q;
    res_period_d = res_period_q;
    res_tmo_d    = res_tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i && pick_any) begin
          sel_d    = pick_grant;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!enable_i)        state_d  = ST_CLEAR;
        else if (settle_done) state_d  = ST_START;
        else                  settle_d = settle_q + 1'b1;
      end
      ST_START: begin
        if (!enable_i) begin
          state_d = ST_CLEAR;
        end else if (pc_if.pc_ready) begin
          pc_start_d = 1'b1;
          presc_d    = '0;
          tmo_d      = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_d = ST_CLEAR;
        end else begin
          if (presc_wrap) begin
            presc_d = '0;
            if (!tmo_hit) tmo_d = tmo_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          // done has priority over a coincident timeout
          if (pc_if.pc_done) begin
            res_valid_d  = 1'b1;
            res_chan_d   = sel_q;
            res_period_d = pc_if.pc_period;
            res_tmo_d    = 1'b0;
            last_d       = sel_q;
            state_d      = ST_STORE;
          end else if (tmo_hit) begin
            res_valid_d  = 1'b1;
            res_chan_d   = sel_q;
            res_period_d = PERIOD_TIMEOUT;
            res_tmo_d    = 1'b1;
            last_d       = sel_q;
            state_d      = ST_STORE;
          end
        end
      end
      ST_STORE: state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    pc_clr_d = (state_d == ST_CLEAR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_q       <= CH_W'(N_CH - 1);
      settle_q     <= '0;
      presc_q      <= '0;
      tmo_q        <= '0;
      pc_start_q   <= 1'b0;
      pc_clr_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_chan_q   <= '0;
      res_period_q <= '0;
      res_tmo_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      settle_q     <= settle_d;
      presc_q      <= presc_d;
      tmo_q        <= tmo_d;
      pc_start_q   <= pc_start_d;
      pc_clr_q     <= pc_clr_d;
      res_valid_q  <= res_valid_d;
      res_chan_q   <= res_chan_d;
      res_period_q <= res_period_d;
      res_tmo_q    <= res_tmo_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign pc_if.pc_si    = si_i[sel_q];
  assign pc_if.pc_start = pc_start_q;
  assign pc_if.pc_clr   = pc_clr_q;

  assign result_valid_o   = res_valid_q;
  assign result_chan_o    = res_chan_q;
  assign result_period_o  = res_period_q;
  assign result_timeout_o = res_tmo_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_period_meas_scheduler.sv
// Directed bench for period_meas_scheduler with a scripted period-counter model.
module tb_period_meas_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] chan_en;
  logic [3:0] si;
  logic       result_valid;
  logic [1:0] result_chan;
  logic [9:0] result_period;
  logic       result_timeout;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  period_meas_scheduler_if pc_if ();

  period_meas_scheduler #(
    .N_CH          (4),
    .CLK_MS_COUNT  (10),
    .SETTLE_CYCLES (4),
    .TIMEOUT_MS    (20)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_i         (enable),
    .chan_en_i        (chan_en),
    .si_i             (si),
    .pc_if            (pc_if.master),
    .result_valid_o   (result_valid),
    .result_chan_o    (result_chan),
    .result_period_o  (result_period),
    .result_timeout_o (result_timeout),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until pc_start is seen, bounded.
  task automatic wait_start(output int n);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (pc_if.pc_start) break;
    end
    chk("start_seen", 32'(pc_if.pc_start), 1);
  endtask

  // One full measurement with the counter reporting per after dly cycles.
  task automatic measure(input int ch, input logic [9:0] per, input int dly, input int gap);
    int n;
    wait_start(n);
    chk("start_gap", 32'(n), 32'(gap));
    si = 4'b0001 << ch;
    #1 chk("pc_si_hi", 32'(pc_if.pc_si), 1);
    si = ~(4'b0001 << ch);
    #1 chk("pc_si_lo", 32'(pc_if.pc_si), 0);
    pc_if.pc_ready = 1'b0;
    tick();
    chk("start_pulse_len", 32'(pc_if.pc_start), 0);
    repeat (dly - 1) tick();
    pc_if.pc_done   = 1'b1;
    pc_if.pc_period = per;
    tick();
    chk("res_valid", 32'(result_valid), 1);
    chk("res_chan", 32'(result_chan), 32'(ch));
    chk("res_period", 32'(result_period), 32'(per));
    chk("res_timeout", 32'(result_timeout), 0);
    tick();
    chk("clr_after_valid", 32'(pc_if.pc_clr), 1);
    chk("valid_one_cycle", 32'(result_valid), 0);
    chk("res_chan_held", 32'(result_chan), 32'(ch));
    pc_if.pc_done   = 1'b0;
    pc_if.pc_period = '0;
    pc_if.pc_ready  = 1'b1;
  endtask

  initial begin
    int n;
    logic seen;

    reset_n         = 1'b0;
    enable          = 1'b0;
    chan_en         = 4'b0000;
    si              = 4'b0000;
    pc_if.pc_ready  = 1'b1;
    pc_if.pc_done   = 1'b0;
    pc_if.pc_period = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_chan", 32'(result_chan), 0);
    chk("rst_period", 32'(result_period), 0);
    chk("rst_timeout", 32'(result_timeout), 0);
    chk("rst_start", 32'(pc_if.pc_start), 0);
    chk("rst_clr", 32'(pc_if.pc_clr), 0);
    si = 4'b0001;
    #1 chk("rst_sel0", 32'(pc_if.pc_si), 1);

    // Round robin over all channels
    enable  = 1'b1;
    chan_en = 4'b1111;
    measure(0, 10'd5,   3, 5);
    measure(1, 10'd17,  1, 6);
    measure(2, 10'h2A,  7, 6);
    measure(3, 10'h3FE, 2, 6);
    chk("busy_between", 32'(busy), 1);
    measure(0, 10'd1,   4, 6);

    // Masking
    chan_en = 4'b1010;
    measure(1, 10'd9,   2, 6);
    measure(3, 10'd100, 3, 6);
    measure(1, 10'd0,   1, 6);
    chan_en = 4'b0000;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (busy || pc_if.pc_start) seen = 1'b1;
    end
    chk("empty_mask_idle", 32'(seen), 0);
    chk("empty_mask_busy", 32'(busy), 0);

    // Timeout: counter never reports done
    chan_en = 4'b0001;
    wait_start(n);
    chk("tmo_start_gap", 32'(n), 5);
    pc_if.pc_ready = 1'b0;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (result_valid) break;
    end
    chk("tmo_latency", 32'(n), 201);
    chk("tmo_flag", 32'(result_timeout), 1);
    chk("tmo_period", 32'(result_period), 32'h3FF);
    chk("tmo_chan", 32'(result_chan), 0);
    tick();
    chk("tmo_clr", 32'(pc_if.pc_clr), 1);
    pc_if.pc_ready = 1'b1;

    // Done arrives in the cycle the timeout count reaches its limit
    wait_start(n);
    chk("sim_start_gap", 32'(n), 6);
    pc_if.pc_ready = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      tick();
      if (result_valid) seen = 1'b1;
    end
    chk("sim_no_early", 32'(seen), 0);
    pc_if.pc_done   = 1'b1;
    pc_if.pc_period = 10'h155;
    tick();
    chk("sim_valid", 32'(result_valid), 1);
    chk("sim_timeout", 32'(result_timeout), 0);
    chk("sim_period", 32'(result_period), 32'h155);
    tick();
    chk("sim_clr", 32'(pc_if.pc_clr), 1);
    pc_if.pc_done   = 1'b0;
    pc_if.pc_period = '0;
    pc_if.pc_ready  = 1'b1;

    // Abort in WAIT; last stays 0 so channel 2 is served again
    chan_en = 4'b0101;
    wait_start(n);
    chk("abort_start_gap", 32'(n), 6);
    si = 4'b0100;
    #1 chk("abort_sel", 32'(pc_if.pc_si), 1);
    pc_if.pc_ready = 1'b0;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("abort_clr", 32'(pc_if.pc_clr), 1);
    chk("abort_no_valid", 32'(result_valid), 0);
    chk("abort_chan_held", 32'(result_chan), 0);
    tick();
    chk("abort_clr_len", 32'(pc_if.pc_clr), 0);
    chk("abort_idle", 32'(busy), 0);
    pc_if.pc_ready = 1'b1;
    repeat (3) tick();
    chk("abort_stays_idle", 32'(busy), 0);
    enable = 1'b1;
    measure(2, 10'h0AB, 2, 5);

    // Asynchronous reset in WAIT
    chan_en = 4'b1111;
    wait_start(n);
    chk("rst_mid_gap", 32'(n), 6);
    pc_if.pc_ready = 1'b0;
    repeat (2) tick();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_chan", 32'(result_chan), 0);
    chk("arst_period", 32'(result_period), 0);
    chk("arst_valid", 32'(result_valid), 0);
    chk("arst_timeout", 32'(result_timeout), 0);
    chk("arst_start", 32'(pc_if.pc_start), 0);
    chk("arst_clr", 32'(pc_if.pc_clr), 0);
    si = 4'b0001;
    #1 chk("arst_sel0", 32'(pc_if.pc_si), 1);
    pc_if.pc_ready = 1'b1;
    pc_if.pc_done  = 1'b0;
    tick();
    reset_n = 1'b1;
    measure(0, 10'd7, 1, 5);
    measure(1, 10'd8, 2, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
